// File: rtl/matmul_pkg.sv
// Shared constants and types for the matmul block.
// Used by the APB master and its stimulus side.
package matmul_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int MAX_DIM    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_mst_state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [MAX_DIM-1:0]    strb;
    logic                  wait_idle;
  } matmul_cmd_t;

endpackage

// File: rtl/matmul_apb_master.sv
// Command/response stream to APB initiator with
// optional wait-for-idle and bounded-wait timeout.
module matmul_apb_master
  import matmul_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  input  logic                  cmd_wait_idle_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  busy_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  apb_mst_state_t       state, state_n;
  matmul_cmd_t          cmd_q, cmd_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic                 psel_q, psel_n;
  logic                 pen_q, pen_n;
  logic                 rv_q, rv_n;
  logic [BUS_WIDTH-1:0] rd_q, rd_n;
  logic                 err_q, err_n;
  logic                 tmo_q, tmo_n;
  logic                 unused_wait_idle;

  assign unused_wait_idle = cmd_q.wait_idle;

  // Next-state and next-output decode for the transfer FSM
  always_comb begin
    state_n = state;
    cmd_n   = cmd_q;
    cnt_n   = cnt_q;
    psel_n  = psel_q;
    pen_n   = pen_q;
    rv_n    = rv_q;
    rd_n    = rd_q;
    err_n   = err_q;
    tmo_n   = tmo_q;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_n.write     = cmd_write_i;
          cmd_n.addr      = cmd_addr_i;
          cmd_n.wdata     = cmd_wdata_i;
          cmd_n.strb      = cmd_write_i ? cmd_strb_i : '0;
          cmd_n.wait_idle = cmd_wait_idle_i;
          cnt_n           = '0;
          if (cmd_wait_idle_i && busy_i) begin
            state_n = ST_WAIT_IDLE;
          end else begin
            state_n = ST_SETUP;
            psel_n  = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (!busy_i) begin
          state_n = ST_SETUP;
          psel_n  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_n = ST_RESP;
          rv_n    = 1'b1;
          rd_n    = '0;
          err_n   = 1'b1;
          tmo_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_SETUP: begin
        state_n = ST_ACCESS;
        pen_n   = 1'b1;
        cnt_n   = '0;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          state_n = ST_RESP;
          psel_n  = 1'b0;
          pen_n   = 1'b0;
          rv_n    = 1'b1;
          rd_n    = cmd_q.write ? '0 : prdata_i;
          err_n   = pslverr_i;
          tmo_n   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_n = ST_RESP;
          psel_n  = 1'b0;
          pen_n   = 1'b0;
          rv_n    = 1'b1;
          rd_n    = '0;
          err_n   = 1'b1;
          tmo_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_n = ST_IDLE;
          rv_n    = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      cmd_q  <= '0;
      cnt_q  <= '0;
      psel_q <= 1'b0;
      pen_q  <= 1'b0;
      rv_q   <= 1'b0;
      rd_q   <= '0;
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cmd_q  <= cmd_n;
      cnt_q  <= cnt_n;
      psel_q <= psel_n;
      pen_q  <= pen_n;
      rv_q   <= rv_n;
      rd_q   <= rd_n;
      err_q  <= err_n;
      tmo_q  <= tmo_n;
    end
  end

  assign cmd_ready_o   = (state == ST_IDLE);
  assign psel_o        = psel_q;
  assign penable_o     = pen_q;
  assign pwrite_o      = cmd_q.write;
  assign paddr_o       = cmd_q.addr;
  assign pwdata_o      = cmd_q.wdata;
  assign pstrb_o       = cmd_q.strb;
  assign rsp_valid_o   = rv_q;
  assign rsp_rdata_o   = rd_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Randomized bench for matmul_apb_master against a
// cycle-schedule reference model.
module tb_matmul_apb_master;
  import matmul_pkg::*;

  localparam int T = 8;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  cmd_valid_i, cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [BUS_WIDTH-1:0]  cmd_wdata_i;
  logic [MAX_DIM-1:0]    cmd_strb_i;
  logic                  cmd_wait_idle_i;
  logic                  rsp_valid_o, rsp_ready_i;
  logic [BUS_WIDTH-1:0]  rsp_rdata_o;
  logic                  rsp_err_o, rsp_timeout_o;
  logic                  psel_o, penable_o, pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [BUS_WIDTH-1:0]  pwdata_o;
  logic [MAX_DIM-1:0]    pstrb_o;
  logic                  pready_i, pslverr_i;
  logic [BUS_WIDTH-1:0]  prdata_i;
  logic                  busy_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matmul_apb_master #(.TIMEOUT(T)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_write_i    (cmd_write_i),
    .cmd_addr_i     (cmd_addr_i),
    .cmd_wdata_i    (cmd_wdata_i),
    .cmd_strb_i     (cmd_strb_i),
    .cmd_wait_idle_i(cmd_wait_idle_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .rsp_timeout_o  (rsp_timeout_o),
    .psel_o         (psel_o),
    .penable_o      (penable_o),
    .pwrite_o       (pwrite_o),
    .paddr_o        (paddr_o),
    .pwdata_o       (pwdata_o),
    .pstrb_o        (pstrb_o),
    .pready_i       (pready_i),
    .pslverr_i      (pslverr_i),
    .prdata_i       (prdata_i),
    .busy_i         (busy_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid_i     = 1'b0;
    cmd_write_i     = 1'b0;
    cmd_addr_i      = '0;
    cmd_wdata_i     = '0;
    cmd_strb_i      = '0;
    cmd_wait_idle_i = 1'b0;
    rsp_ready_i     = 1'b0;
    pready_i        = 1'b0;
    pslverr_i       = 1'b0;
    prdata_i        = '0;
    busy_i          = 1'b0;
  endtask

  // Window k is the cycle after the k-th edge counted
  // from the handshake edge; inputs driven at negedge k
  // are sampled at the end of window k.
  task automatic txn(input logic wr,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input logic [3:0] strb,
                     input logic wi,
                     input int b,
                     input int d,
                     input logic err,
                     input int bp);
    int w, s, a, r, last;
    logic tmo;
    logic [31:0] exp_rd;
    logic e_sel, e_en, e_rv, e_cr;
    exp_rd = '0;
    w = (wi && b > 0) ? ((b > T) ? T : b) : 0;
    if (wi && b > T) begin
      tmo = 1'b1;
      s   = -1000;
      a   = 0;
      r   = T + 1;
    end else begin
      s   = w + 1;
      a   = (d >= T) ? T : d + 1;
      tmo = (d >= T);
      r   = s + a + 1;
    end
    last = r + bp + 1;
    @(negedge clk);
    chk("cmd_ready_start", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i     = 1'b1;
    cmd_write_i     = wr;
    cmd_addr_i      = addr;
    cmd_wdata_i     = wdata;
    cmd_strb_i      = strb;
    cmd_wait_idle_i = wi;
    busy_i          = (b > 0);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      e_en  = (k > s && k <= s + a);
      e_sel = (k == s) || e_en;
      e_rv  = (k >= r && k < last);
      e_cr  = (k == last);
      chk("psel", 32'(psel_o), 32'(e_sel));
      chk("penable", 32'(penable_o), 32'(e_en));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rv));
      chk("cmd_ready", 32'(cmd_ready_o), 32'(e_cr));
      if (e_sel) begin
        chk("paddr", paddr_o, addr);
        chk("pwrite", 32'(pwrite_o), 32'(wr));
        chk("pwdata", pwdata_o, wdata);
        chk("pstrb", 32'(pstrb_o),
            wr ? 32'(strb) : 32'd0);
      end
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata_o,
            (wr || tmo) ? 32'd0 : exp_rd);
        chk("rsp_err", 32'(rsp_err_o),
            32'(tmo | err));
        chk("rsp_timeout", 32'(rsp_timeout_o),
            32'(tmo));
      end
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'($urandom);
      cmd_addr_i  = $urandom;
      cmd_wdata_i = $urandom;
      cmd_strb_i  = 4'($urandom);
      busy_i      = (k < b);
      pready_i    = !tmo && (k == s + 1 + d);
      prdata_i    = $urandom;
      pslverr_i   = pready_i ? err : 1'($urandom);
      if (pready_i) exp_rd = prdata_i;
      if (k >= r + bp)   rsp_ready_i = 1'b1;
      else if (k >= r)   rsp_ready_i = 1'b0;
      else               rsp_ready_i = 1'($urandom);
    end
    idle_inputs();
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b0;
    cmd_addr_i  = 32'h40;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_penable", 32'(penable_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst_psel", 32'(psel_o), 32'd0);
    chk("rst_penable", 32'(penable_o), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_paddr", paddr_o, 32'd0);
    for (int i = 0; i < 4; i++) begin
      pready_i = 1'b1;
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid_o), 32'd0);
      chk("rst_no_psel", 32'(psel_o), 32'd0);
    end
    idle_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("reset_psel", 32'(psel_o), 32'd0);
    chk("reset_penable", 32'(penable_o), 32'd0);
    chk("reset_pwrite", 32'(pwrite_o), 32'd0);
    chk("reset_paddr", paddr_o, 32'd0);
    chk("reset_pwdata", pwdata_o, 32'd0);
    chk("reset_pstrb", 32'(pstrb_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("reset_rsp_tmo", 32'(rsp_timeout_o), 32'd0);
    rst_i = 1'b0;

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF,
        1'b0, 0, 0, 1'b0, 0);
    txn(1'b0, 32'h20, 32'h0, 4'hF,
        1'b0, 0, 3, 1'b0, 0);
    txn(1'b1, 32'h30, 32'hCAFE0001, 4'h5,
        1'b0, 0, 1, 1'b1, 0);
    txn(1'b0, 32'h24, 32'h0, 4'h0,
        1'b0, 0, 20, 1'b0, 1);
    txn(1'b0, 32'h28, 32'h0, 4'h0,
        1'b0, 0, T - 1, 1'b0, 0);
    txn(1'b1, 32'h2C, 32'h11223344, 4'h3,
        1'b1, 5, 0, 1'b0, 0);
    txn(1'b0, 32'h34, 32'h0, 4'h0,
        1'b1, 12, 0, 1'b0, 2);
    txn(1'b1, 32'h38, 32'h55AA55AA, 4'hC,
        1'b1, T, 2, 1'b0, 0);
    txn(1'b0, 32'h3C, 32'h0, 4'h0,
        1'b0, 6, 0, 1'b0, 4);
    reset_mid_access();

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), $urandom, $urandom,
          4'($urandom), 1'($urandom),
          int'($urandom_range(0, 11)),
          int'($urandom_range(0, 10)),
          1'($urandom),
          int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_apb_master.md
# matmul_apb_master

APB initiator that drives the matmul accelerator's APB slave port from a simple command/response stream. It turns each accepted command into one APB read or write (SETUP then ACCESS), waits on `pready_i` and returns read data and the error status. It also provides an optional wait-for-idle on `busy_i` and a bounded-wait timeout, so testbench stimulus and on-chip controllers never hang on a stalled slave.

## Interface
- `BUS_WIDTH`, 32, APB data width (from `matmul_pkg`)
- `ADDR_WIDTH`, 32, APB address width (from `matmul_pkg`)
- `MAX_DIM`, 4, strobe width; one bit per data lane (from `matmul_pkg`)
- `TIMEOUT`, 64, maximum cycles spent in ACCESS or WAIT_IDLE before abort; must be ≥1
- `clk_i`  in  1  clock; all logic on the rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `cmd_valid_i`  in  1  command present
- `cmd_ready_o`  out  1  command accepted this cycle when both valid and ready are high
- `cmd_write_i`  in  1  1 = write, 0 = read
- `cmd_addr_i`  in  ADDR_WIDTH  target address
- `cmd_wdata_i`  in  BUS_WIDTH  write data
- `cmd_strb_i`  in  MAX_DIM  write strobes
- `cmd_wait_idle_i`  in  1  hold off the APB phase until `busy_i`=0
- `rsp_valid_o`  out  1  response present
- `rsp_ready_i`  in  1  response consumed
- `rsp_rdata_o`  out  BUS_WIDTH  read data; 0 for writes and on timeout
- `rsp_err_o`  out  1  `pslverr_i` was sampled high, or a timeout occurred
- `rsp_timeout_o`  out  1  abort was caused by the timeout
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB controls
- `paddr_o`  out  ADDR_WIDTH; `pwdata_o`  out  BUS_WIDTH; `pstrb_o`  out  MAX_DIM
- `pready_i`, `pslverr_i`  in  1; `prdata_i`  in  BUS_WIDTH
- `busy_i`  in  1  accelerator busy flag

## Operation
- The FSM has five states: IDLE, WAIT_IDLE, SETUP, ACCESS, RESP.
- **IDLE:** `cmd_ready_o`=1. On handshake, latch the full command.
  - If `cmd_wait_idle_i`=1 and `busy_i`=1, go to WAIT_IDLE.
  - Otherwise go to SETUP.
- **WAIT_IDLE:** go to SETUP in the cycle after `busy_i` is sampled low. The timeout counter runs here.
- **SETUP:** `psel_o`=1, `penable_o`=0, and address, data and controls are valid. Always go to ACCESS next cycle.
- **ACCESS:** `psel_o`=1, `penable_o`=1, and all APB outputs are held stable.
  - When `pready_i`=1, capture `prdata_i` (reads only) and `pslverr_i`, then go to RESP.
- **RESP:** `rsp_valid_o`=1, with response fields held stable. When `rsp_ready_i`=1, go to IDLE.
- **Timeout:** a counter clears on entry to WAIT_IDLE or ACCESS and increments each cycle spent there.
  - If the counter reaches `TIMEOUT-1` and the exit condition is not met that cycle, go to RESP with `rsp_err_o`=1, `rsp_timeout_o`=1 and `rsp_rdata_o`=0.
  - `psel_o` drops in that same transition.
- **Outputs:** `pstrb_o` is forced to 0 on reads (APB4 rule). `pwdata_o` is don't-care on reads and is driven with the latched value.
- **Status in RESP:** `rsp_err_o` equals the captured `pslverr_i`; `rsp_timeout_o`=0 unless a timeout occurred.
- **No pipelining:** one outstanding command at most. `cmd_ready_o`=0 in every state except IDLE.

## Timing
- **Reset values:** state IDLE; `cmd_ready_o`=1 from the first cycle after reset. All other outputs are 0: `psel_o`, `penable_o`, `pwrite_o`, `paddr_o`, `pwdata_o`, `pstrb_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`, `rsp_timeout_o`.
- **Best-case latency:** command handshake at edge N → SETUP in cycle N+1 → ACCESS in cycle N+2 → with `pready_i`=1 in that cycle, `rsp_valid_o`=1 in cycle N+3.
- **Throughput:** one command per 4 cycles at best, because `cmd_ready_o` returns the cycle after the RESP handshake.
- **Wait states:** each cycle with `pready_i`=0 in ACCESS adds one cycle. The APB outputs must not change.
- **Timeout boundary:** `pready_i`=1 arriving on the cycle the counter hits `TIMEOUT-1` counts as a normal completion, not a timeout.
- **Response backpressure:** holding `rsp_ready_i`=0 keeps the response fields and `rsp_valid_o` stable indefinitely.
- **Reset mid-transfer:** `rst_i` in any state returns the block to IDLE next edge. `psel_o` drops immediately and no response is produced.
- **Registered outputs:** all APB and response outputs come from flops. `cmd_ready_o` is decoded from state.

## Structure
- `matmul_pkg` holds:
  - the shared constants `BUS_WIDTH`, `ADDR_WIDTH` and `MAX_DIM`;
  - a new `apb_mst_state_t` enum for the five states;
  - a `matmul_cmd_t` struct (write, addr, wdata, strb, wait_idle).
- Single module; no sub-module needed. The timeout counter width is `$clog2(TIMEOUT+1)`.
- Connects to `matmul_intf` through the STIMULUS-side signal set: APB outputs, plus `pready`/`pslverr`/`prdata`/`busy` as inputs.

## Test plan
- **Write, zero wait:** write addr 0x10, data 0xDEADBEEF, strb 4'hF, slave ready at once → `psel_o` at N+1, `penable_o` at N+2, `rsp_valid_o` at N+3 with `rsp_err_o`=0 and `rsp_rdata_o`=0.
- **Read with wait states:** read addr 0x20, `pready_i` low for 3 ACCESS cycles, then high with `prdata_i`=0x12345678 → APB outputs stable throughout, `rsp_rdata_o`=0x12345678, and `pstrb_o`=0 during the whole transfer.
- **Slave error:** write with `pslverr_i`=1 on the ready cycle → `rsp_err_o`=1, `rsp_timeout_o`=0.
- **Timeout:** `TIMEOUT`=8, `pready_i` held 0 → exactly 8 ACCESS cycles, then `psel_o`=0 and `rsp_err_o`=`rsp_timeout_o`=1.
  - Repeat with `pready_i` rising on the 8th cycle → normal completion.
- **Wait-idle:** `cmd_wait_idle_i`=1 with `busy_i` high for 5 cycles → `psel_o` rises the cycle after `busy_i` is sampled low.
- **Backpressure and reset:**
  - `rsp_ready_i`=0 for 4 cycles → response held and `cmd_ready_o`=0.
  - `rst_i` asserted in ACCESS → next cycle IDLE, `psel_o`=0, no response emitted.
